stage_instruction_fetch_q: RTL

//  Decoupled instruction-fetch stage: issues in-order requests to instruction memory over a

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_queue.sv | 59 +++++
 rtl/stage_instruction_fetch_q.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the decoupled instruction-fetch stage.
// Entries carry the instruction word and the PC it was fetched from.
package fetch_pkg;

    localparam int FETCH_XLEN  = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] instr;
        logic [FETCH_XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of fetch_entry_t with synchronous flush; the head entry is read
// straight from registered storage so decode sees registered data.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  fetch_entry_t wdata,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot at the edge, so a push into a full queue is fine then.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/stage_instruction_fetch_q.sv
// Decoupled instruction fetch: credit-limited in-order requests, drop counter for
// post-redirect responses, prefetch queue to decode. Optional macro: IF_PERF_CNT_EN.
module stage_instruction_fetch_q
    import fetch_pkg::*;
#(
    parameter int               XLEN     = FETCH_XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ex_redirect,
    input  logic [XLEN-1:0] ex_pc_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            de_valid,
    input  logic            de_ready,
    output logic [XLEN-1:0] de_instr,
    output logic [XLEN-1:0] de_pc,
    output logic [XLEN-1:0] de_pc_plus4
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_stall_cycles,
    output logic [31:0]     perf_redirects
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    logic            active;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   inflight_next;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   q_count;
    logic [CW:0]     occupancy;
    logic            q_full;
    logic            q_empty;
    logic            req_fire;
    logic            resp_drop;
    logic            push;
    logic            pop;
    fetch_entry_t    q_wdata;
    fetch_entry_t    q_head;

    // Queued plus in-flight never exceeds DEPTH, so every response has a slot.
    assign occupancy      = {1'b0, q_count} + {1'b0, inflight};
    assign imem_req_valid = active && !ex_redirect && (occupancy < (CW + 1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign resp_drop      = imem_resp_valid && (drop != '0);
    assign push           = imem_resp_valid && (drop == '0) && !ex_redirect;
    assign pop            = !q_empty && de_ready;
    assign inflight_next  = inflight + CW'(req_fire) - CW'(imem_resp_valid);

    assign q_wdata.instr  = imem_resp_data;
    assign q_wdata.pc     = resp_pc;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (q_wdata),
        .pop     (pop),
        .flush   (ex_redirect),
        .head    (q_head),
        .count   (q_count),
        .full    (q_full),
        .empty   (q_empty)
    );

    assign de_valid    = !q_empty;
    assign de_instr    = q_head.instr;
    assign de_pc       = q_head.pc;
    assign de_pc_plus4 = de_valid ? (q_head.pc + XLEN'(INSTR_BYTES)) : '0;

    // active holds off the first request one cycle past reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active   <= 1'b0;
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else begin
            active   <= 1'b1;
            inflight <= inflight_next;
            if (ex_redirect) begin
                fetch_pc <= ex_pc_target;
                resp_pc  <= ex_pc_target;
                drop     <= inflight_next;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
                end
                if (push) begin
                    resp_pc <= resp_pc + XLEN'(INSTR_BYTES);
                end
                if (resp_drop) begin
                    drop <= drop - 1'b1;
                end
            end
        end
    end

    a_no_push_on_full: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && q_full && !pop));

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall_cycles <= '0;
            perf_redirects    <= '0;
        end else begin
            if (!de_valid && (perf_stall_cycles != '1)) begin
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
            end
            if (ex_redirect && (perf_redirects != '1)) begin
                perf_redirects <= perf_redirects + 1'b1;
            end
        end
    end
`endif

endmodule
